// File: rtl/obi_mem_responder.sv
// OBI subordinate: word-addressed scratchpad with byte-enable writes, a fixed
// response latency and an optional periodic grant-stall pattern.
package obi_mem_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned GNT_STALL_EVERY = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    req_i,
  output obi_resp_t   resp_o,
  output logic [31:0] accesses_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          stall;
  logic          accept;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH];

  logic        pipe_valid [READ_LATENCY];
  logic [31:0] pipe_data  [READ_LATENCY];

  assign idx    = req_i.addr[AW+1:2];
  assign accept = req_i.req & ~stall;

  // Free-running stall counter; runs regardless of req so the pattern is fixed in time.
  generate
    if (GNT_STALL_EVERY >= 2) begin : g_stall
      localparam int unsigned CW = $clog2(GNT_STALL_EVERY);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt <= '0;
        end else if (cnt == CW'(GNT_STALL_EVERY - 1)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign stall = (cnt == CW'(GNT_STALL_EVERY - 1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  // Memory array is deliberately not reset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && req_i.we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_i.be[k]) begin
          mem[idx][8*k +: 8] <= req_i.wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_data[s]  <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= (accept && !req_i.we) ? mem[idx] : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accesses_o <= '0;
    end else if (accept) begin
      accesses_o <= accesses_o + 32'd1;
    end
  end

  always_comb begin
    resp_o        = '0;
    resp_o.gnt    = accept;
    resp_o.rvalid = pipe_valid[READ_LATENCY-1];
    resp_o.rdata  = pipe_data[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: four instances cover latency 1/3,
// a 1-in-4 grant stall and a 16-word aliasing configuration.
module tb_obi_mem_responder;
  import obi_mem_pkg::*;

  logic        clk = 1'b0;
  logic [3:0]  rst_n;
  obi_req_t    req_v  [4];
  obi_resp_t   resp_v [4];
  logic [31:0] acc_v  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: basic, 1: latency 3, 2: stall every 4, 3: depth 16
  obi_mem_responder #(.DEPTH(1024), .READ_LATENCY(1), .GNT_STALL_EVERY(0)) u_basic (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req_v[0]), .resp_o(resp_v[0]), .accesses_o(acc_v[0]));
  obi_mem_responder #(.DEPTH(1024), .READ_LATENCY(3), .GNT_STALL_EVERY(0)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req_v[1]), .resp_o(resp_v[1]), .accesses_o(acc_v[1]));
  obi_mem_responder #(.DEPTH(1024), .READ_LATENCY(1), .GNT_STALL_EVERY(4)) u_stall (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req_v[2]), .resp_o(resp_v[2]), .accesses_o(acc_v[2]));
  obi_mem_responder #(.DEPTH(16), .READ_LATENCY(1), .GNT_STALL_EVERY(0)) u_d16 (
    .clk_i(clk), .rst_ni(rst_n[3]), .req_i(req_v[3]), .resp_o(resp_v[3]), .accesses_o(acc_v[3]));

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [31:0] exp_acc;
  } vec_t;

  vec_t vecs [10];

  task automatic applyStimulus(input int d, input logic rq, input logic we,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
    @(negedge clk);
    req_v[d] = '{req: rq, addr: addr, we: we, be: be, wdata: wdata};
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int pulses;

    for (int d = 0; d < 4; d++) req_v[d] = '0;
    rst_n = 4'b0000;

    // Reset state: gnt follows req, no responses, counter cleared
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    req_v[2] = '{req: 1'b1, addr: 32'h0, we: 1'b1, be: 4'h0, wdata: 32'h0};
    #1;
    checkOutput("reset gnt basic", {31'd0, resp_v[0].gnt}, 32'd1);
    checkOutput("reset gnt stall", {31'd0, resp_v[2].gnt}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("reset rvalid %0d", d), {31'd0, resp_v[d].rvalid}, 32'd0);
      checkOutput($sformatf("reset rdata %0d", d), resp_v[d].rdata, 32'd0);
      checkOutput($sformatf("reset acc %0d", d), acc_v[d], 32'd0);
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Stall pattern: req held 8 cycles from the first cycle out of reset
    @(negedge clk);
    rst_n = 4'b1111;
    #1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) applyStimulus(2, (c < 8), 1'b1, 32'h0, 4'h0, 32'h0);
      if (c < 8)
        checkOutput($sformatf("stall gnt c%0d", c), {31'd0, resp_v[2].gnt},
                    (c % 4 == 3) ? 32'd0 : 32'd1);
      if (resp_v[2].rvalid) pulses++;
    end
    checkOutput("stall responses", pulses, 32'd6);
    checkOutput("stall acc", acc_v[2], 32'd6);

    // Table: basic read/write, byte enables, be=0 no-op, addr[1:0] ignored
    vecs[0] = '{1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        32'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0,        32'd1};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 32'd2};
    vecs[3] = '{1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0,        32'd2};
    vecs[4] = '{1'b1, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 1'b1, 1'b1, 32'h0,        32'd3};
    vecs[5] = '{1'b1, 1'b0, 32'h20, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0,        32'd4};
    vecs[6] = '{1'b1, 1'b1, 32'h21, 4'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h11BB33DD, 32'd5};
    vecs[7] = '{1'b1, 1'b0, 32'h23, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0,        32'd6};
    vecs[8] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'h11BB33DD, 32'd7};
    vecs[9] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        32'd7};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      checkOutput($sformatf("vec%0d gnt", i), {31'd0, resp_v[0].gnt}, {31'd0, vecs[i].exp_gnt});
      checkOutput($sformatf("vec%0d rvalid", i), {31'd0, resp_v[0].rvalid}, {31'd0, vecs[i].exp_rvalid});
      checkOutput($sformatf("vec%0d rdata", i), resp_v[0].rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d acc", i), acc_v[0], vecs[i].exp_acc);
    end

    // Latency 3: four writes, four back-to-back reads, responses in order
    for (int c = 0; c < 12; c++) begin
      if (c < 4)      applyStimulus(1, 1'b1, 1'b1, 32'(c * 4), 4'hF, 32'h10000000 + 32'(c));
      else if (c < 8) applyStimulus(1, 1'b1, 1'b0, 32'((c - 4) * 4), 4'h0, 32'h0);
      else            applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      checkOutput($sformatf("lat3 gnt c%0d", c), {31'd0, resp_v[1].gnt}, (c < 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat3 rvalid c%0d", c), {31'd0, resp_v[1].rvalid},
                  (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lat3 rdata c%0d", c), resp_v[1].rdata,
                  (c >= 7 && c <= 10) ? 32'h10000000 + 32'(c - 7) : 32'h0);
    end
    checkOutput("lat3 acc", acc_v[1], 32'd8);

    // Reset mid-flight: two reads granted, reset one cycle later
    applyStimulus(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    @(negedge clk);
    req_v[1] = '0;
    rst_n[1] = 1'b0;
    #1;
    checkOutput("midrst rvalid", {31'd0, resp_v[1].rvalid}, 32'd0);
    checkOutput("midrst acc", acc_v[1], 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_n[1] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      if (resp_v[1].rvalid) pulses++;
    end
    checkOutput("midrst late pulses", pulses, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    for (int c = 0; c < 3; c++) applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("midrst read rvalid", {31'd0, resp_v[1].rvalid}, 32'd1);
    checkOutput("midrst read rdata", resp_v[1].rdata, 32'h10000002);
    checkOutput("midrst read acc", acc_v[1], 32'd1);

    // Aliasing with 16 words: 0x44 maps onto the same word as 0x04
    applyStimulus(3, 1'b1, 1'b1, 32'h04, 4'hF, 32'hCAFE0001);
    applyStimulus(3, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
    applyStimulus(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("alias rvalid", {31'd0, resp_v[3].rvalid}, 32'd1);
    checkOutput("alias rdata", resp_v[3].rdata, 32'hCAFE0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
